// File: rtl/mac_accum_l2.sv
// Signed multiply-accumulate stage: sums ACC_LEN products of the delayed sample
// stream and hands each result to a back-pressured consumer with a sticky overflow flag.
module mac_accum_l2 #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COEF_W  = 16,
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned ACC_W   = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [COEF_W-1:0] coeff_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  data_out,
  output logic              overflow
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          count, count_nxt;
  logic signed [PROD_W-1:0]  prod, prod_nxt, prod_c;
  logic                      p_valid, p_valid_nxt;
  logic signed [ACC_W-1:0]   acc, acc_nxt, prod_ext_c, sum_c;
  logic                      ovf_acc, ovf_acc_nxt, add_ovf_c;
  logic                      out_valid_nxt, overflow_nxt;
  logic [ACC_W-1:0]          data_out_nxt;
  logic                      accept_c;

  assign in_ready   = (state == ACCUM);
  assign accept_c   = in_valid && in_ready;
  assign prod_c     = $signed(data_in) * $signed(coeff_in);
  assign prod_ext_c = ACC_W'(prod);
  assign sum_c      = acc + prod_ext_c;
  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign add_ovf_c  = (acc[ACC_W-1] == prod_ext_c[ACC_W-1]) &&
                      (sum_c[ACC_W-1] != acc[ACC_W-1]);

  // Next-state and datapath updates; clear overrides everything except data_out.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    prod_nxt      = accept_c ? prod_c : prod;
    p_valid_nxt   = accept_c;
    acc_nxt       = acc;
    ovf_acc_nxt   = ovf_acc;
    out_valid_nxt = out_valid;
    data_out_nxt  = data_out;
    overflow_nxt  = overflow;

    case (state)
      ACCUM: begin
        if (p_valid) begin
          acc_nxt     = sum_c;
          ovf_acc_nxt = ovf_acc | add_ovf_c;
        end
        if (accept_c) begin
          if (count == CNT_W'(ACC_LEN - 1)) begin
            count_nxt = '0;
            state_nxt = DRAIN;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        // The last product of the window is still in the product register here.
        data_out_nxt  = p_valid ? sum_c : acc;
        overflow_nxt  = ovf_acc | (p_valid & add_ovf_c);
        out_valid_nxt = 1'b1;
        acc_nxt       = '0;
        ovf_acc_nxt   = 1'b0;
        state_nxt     = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase

    if (clear) begin
      count_nxt     = '0;
      p_valid_nxt   = 1'b0;
      acc_nxt       = '0;
      ovf_acc_nxt   = 1'b0;
      out_valid_nxt = 1'b0;
      overflow_nxt  = 1'b0;
      state_nxt     = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      count     <= '0;
      prod      <= '0;
      p_valid   <= 1'b0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      prod      <= prod_nxt;
      p_valid   <= p_valid_nxt;
      acc       <= acc_nxt;
      ovf_acc   <= ovf_acc_nxt;
      out_valid <= out_valid_nxt;
      data_out  <= data_out_nxt;
      overflow  <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_mac_accum_l2.sv
// Bench for mac_accum_l2: 40-bit and 32-bit accumulator instances share stimulus
// and are checked against a window-level arithmetic model.
module tb_mac_accum_l2;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [15:0] data_in, coeff_in;
  logic        in_ready, out_valid, overflow;
  logic [39:0] data_out;
  logic        in_ready32, out_valid32, overflow32;
  logic [31:0] data_out32;

  int checks = 0;
  int errors = 0;
  logic [63:0] last40, last32;

  always #5 clk = ~clk;

  mac_accum_l2 #(.DATA_W(16), .COEF_W(16), .ACC_LEN(4), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .coeff_in(coeff_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .overflow(overflow));

  mac_accum_l2 #(.DATA_W(16), .COEF_W(16), .ACC_LEN(4), .ACC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready32),
    .data_in(data_in), .coeff_in(coeff_in), .out_valid(out_valid32), .out_ready(out_ready),
    .data_out(data_out32), .overflow(overflow32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sequential signed adds in a w-bit register; flags any out-of-range intermediate sum.
  function automatic void model(input int w, input longint p[4],
                                output logic [63:0] res, output logic ovf);
    longint s, e, mx, mn, m;
    m  = (longint'(1) <<< w) - 1;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    s = 0;
    ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = s + p[i];
      if (e > mx || e < mn) ovf = 1'b1;
      e = e & m;
      if (e > mx) e = e - (m + 1);
      s = e;
    end
    res = 64'(s & m);
  endfunction

  task automatic feed(input string tag, input logic signed [15:0] d[4],
                      input logic signed [15:0] c[4], input int max_gap);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      data_in  = d[i];
      coeff_in = c[i];
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(1));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_window(input string tag, input logic signed [15:0] d[4],
                            input logic signed [15:0] c[4], input int max_gap, input int hold);
    longint p[4];
    logic [63:0] r40, r32;
    logic o40, o32;
    for (int i = 0; i < 4; i++) p[i] = longint'(d[i]) * longint'(c[i]);
    model(40, p, r40, o40);
    model(32, p, r32, o32);
    out_ready = (hold == 0);
    feed(tag, d, c, max_gap);
    chk({tag, ".drain_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, ".drain_out_valid"}, 64'(out_valid), 64'(0));
    step();
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(1));
    chk({tag, ".data_out"}, 64'(data_out), r40);
    chk({tag, ".overflow"}, 64'(overflow), 64'(o40));
    chk({tag, ".data_out32"}, 64'(data_out32), r32);
    chk({tag, ".overflow32"}, 64'(overflow32), 64'(o32));
    chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
    if (hold > 0) begin
      repeat (hold) begin
        step();
        chk({tag, ".held_valid"}, 64'(out_valid), 64'(1));
        chk({tag, ".held_data"}, 64'(data_out), r40);
        chk({tag, ".held_in_ready"}, 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
    end
    step();
    chk({tag, ".done_valid"}, 64'(out_valid), 64'(0));
    chk({tag, ".done_in_ready"}, 64'(in_ready), 64'(1));
    last40 = r40;
    last32 = r32;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] d[4], c[4];
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    data_in = '0; coeff_in = '0;

    // Reset held while inputs toggle
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom); out_ready = 1'($urandom); clear = 1'($urandom);
      data_in = 16'($urandom); coeff_in = 16'($urandom);
      #1;
      chk("rst.out_valid", 64'(out_valid), 64'(0));
      chk("rst.data_out", 64'(data_out), 64'(0));
      chk("rst.overflow", 64'(overflow), 64'(0));
      chk("rst.in_ready", 64'(in_ready), 64'(1));
    end
    @(negedge clk);
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    run_window("basic", '{16'sd1, 16'sd2, 16'sd3, 16'sd4}, '{4{16'sd2}}, 0, 0);
    chk("basic.value", last40, 64'd20);
    run_window("backp", '{16'sd1, 16'sd2, 16'sd3, 16'sd4}, '{4{16'sd2}}, 0, 5);
    run_window("restart", '{4{16'sd1}}, '{4{16'sd1}}, 0, 0);
    chk("restart.value", last40, 64'd4);
    run_window("signed", '{-16'sd3, 16'sd7, -16'sd32768, 16'sd100},
               '{16'sd5, -16'sd1, 16'sd1, 16'sd100}, 3, 0);
    chk("signed.value", last40, 64'hFF_FFFF_A6FA);
    run_window("wrap", '{4{-16'sd32768}}, '{4{-16'sd32768}}, 0, 0);
    chk("wrap.value32", last32, 64'd0);
    run_window("clean", '{16'sd10, -16'sd20, 16'sd30, 16'sd40}, '{16'sd3, 16'sd3, -16'sd3, 16'sd3}, 1, 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = 16'($urandom);
        c[i] = 16'($urandom);
      end
      run_window("rand", d, c, 2, int'($urandom_range(3, 0)));
    end

    // Clear mid-window: sample presented with clear is discarded
    out_ready = 1'b1;
    in_valid = 1'b1; data_in = 16'd5; coeff_in = 16'd1;
    step();
    step();
    clear = 1'b1; data_in = 16'd9;
    chk("clr.in_ready", 64'(in_ready), 64'(1));
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr.out_valid", 64'(out_valid), 64'(0));
    chk("clr.data_hold", 64'(data_out), last40);
    chk("clr.overflow", 64'(overflow), 64'(0));
    run_window("afterclr", '{16'sd1, 16'sd2, 16'sd3, 16'sd4}, '{4{16'sd1}}, 0, 0);
    chk("afterclr.value", last40, 64'd10);

    // Clear beats out_ready in HOLD
    out_ready = 1'b0;
    feed("clrhold", '{4{16'sd2}}, '{4{16'sd3}}, 0);
    step();
    chk("clrhold.valid", 64'(out_valid), 64'(1));
    chk("clrhold.data", 64'(data_out), 64'd24);
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0;
    chk("clrhold.dropped", 64'(out_valid), 64'(0));
    chk("clrhold.data_kept", 64'(data_out), 64'd24);
    chk("clrhold.in_ready", 64'(in_ready), 64'(1));

    // Async reset during HOLD
    out_ready = 1'b0;
    feed("rsthold", '{4{16'sd7}}, '{4{16'sd7}}, 0);
    step();
    chk("rsthold.valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rsthold.valid_drop", 64'(out_valid), 64'(0));
    chk("rsthold.data_zero", 64'(data_out), 64'(0));
    chk("rsthold.data32_zero", 64'(data_out32), 64'(0));
    chk("rsthold.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_window("postrst", '{16'sd4, 16'sd3, 16'sd2, 16'sd1}, '{4{-16'sd1}}, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
